// File: rtl/lab3_btn_ctrl.sv
// lab3_btn_ctrl: control stage in front of the 16-bit LED shifter.
// It synchronises and debounces the enable and direction buttons. Each
// debounced press produces a one-cycle pulse and toggles a level output.
// A free-running counter produces the shifter's step tick as a clock enable.
module lab3_btn_ctrl #(
    parameter logic [15:0] DEB_CYCLES = 16'd50000,
    parameter int unsigned TICK_W     = 25
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_en,
    input  logic btn_dir,
    output logic en,
    output logic dir,
    output logic en_pulse,
    output logic dir_pulse,
    output logic tick
);

    // The counter's last value before a debounced state is allowed to flip.
    localparam logic [15:0] DEB_LAST = DEB_CYCLES - 16'd1;

    // Index 0 is the enable button, index 1 is the direction button.
    logic [1:0]        btn_s;
    logic [1:0]        sync1_r;
    logic [1:0]        sync2_r;
    logic [1:0]        db_r;
    logic [1:0]        db_nxt_s;
    logic [1:0]        press_s;
    logic [1:0]        pulse_r;
    logic [1:0]        level_r;
    logic [15:0]       cnt_r     [2];
    logic [15:0]       cnt_nxt_s [2];
    logic [TICK_W-1:0] tick_cnt_r;
    logic              tick_r;

    assign btn_s = {btn_dir, btn_en};

    // Two-flop synchroniser for both raw, asynchronous buttons.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 2'b00;
            sync2_r <= 2'b00;
        end else begin
            sync1_r <= btn_s;
            sync2_r <= sync1_r;
        end
    end

    // Debounce next-state logic. A button's state changes only after its
    // synchronised level has differed from the debounced state for
    // DEB_CYCLES consecutive cycles.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            cnt_nxt_s[i] = 16'd0;
            db_nxt_s[i]  = db_r[i];
            if (sync2_r[i] == db_r[i]) begin
                cnt_nxt_s[i] = 16'd0;
            end else if (cnt_r[i] < DEB_LAST) begin
                cnt_nxt_s[i] = cnt_r[i] + 16'd1;
            end else begin
                db_nxt_s[i]  = sync2_r[i];
                cnt_nxt_s[i] = 16'd0;
            end
        end
    end

    // A press is the 0->1 transition of the debounced state, seen one cycle early.
    assign press_s = db_nxt_s & ~db_r;

    // Debounce state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            db_r     <= 2'b00;
            cnt_r[0] <= 16'd0;
            cnt_r[1] <= 16'd0;
        end else begin
            db_r     <= db_nxt_s;
            cnt_r[0] <= cnt_nxt_s[0];
            cnt_r[1] <= cnt_nxt_s[1];
        end
    end

    // Press pulses and toggled levels update on the edge where db rises.
    always_ff @(posedge clk) begin
        if (rst) begin
            pulse_r <= 2'b00;
            level_r <= 2'b00;
        end else begin
            pulse_r <= press_s;
            level_r <= level_r ^ press_s;
        end
    end

    // Free-running step counter. The registered tick fires in the cycle
    // after the counter holds all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt_r <= {TICK_W{1'b0}};
            tick_r     <= 1'b0;
        end else begin
            tick_cnt_r <= tick_cnt_r + {{(TICK_W-1){1'b0}}, 1'b1};
            tick_r     <= (tick_cnt_r == {TICK_W{1'b1}});
        end
    end

    assign en        = level_r[0];
    assign dir       = level_r[1];
    assign en_pulse  = pulse_r[0];
    assign dir_pulse = pulse_r[1];
    assign tick      = tick_r;

endmodule

// File: tb/tb_lab3_btn_ctrl.sv
// Self-checking bench for lab3_btn_ctrl using DEB_CYCLES=4 and TICK_W=4.
// For each press it drives, the bench pushes the edge number at which the
// press pulse is expected. A per-cycle monitor pops these entries and
// compares all five outputs after every clock edge.
module tb_lab3_btn_ctrl;

    localparam int DEB = 4;
    localparam int TP  = 16;

    logic clk     = 1'b0;
    logic rst     = 1'b1;
    logic btn_en  = 1'b0;
    logic btn_dir = 1'b0;
    logic en, dir, en_pulse, dir_pulse, tick;

    int   n_vec    = 0;
    int   n_bad    = 0;
    int   cyc      = 0;
    int   last_rst = 0;
    int   en_q  [$];
    int   dir_q [$];
    logic exp_en   = 1'b0;
    logic exp_dir  = 1'b0;

    always #5 clk = ~clk;

    lab3_btn_ctrl #(
        .DEB_CYCLES (16'd4),
        .TICK_W     (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_en    (btn_en),
        .btn_dir   (btn_dir),
        .en        (en),
        .dir       (dir),
        .en_pulse  (en_pulse),
        .dir_pulse (dir_pulse),
        .tick      (tick)
    );

    task automatic chk(input string tag, input logic got, input logic exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at edge %0d: got %b, expected %b", tag, cyc, got, exp);
        end
    endtask

    // Advance one clock edge, then check every output against the scoreboard.
    task automatic step();
        logic rs;
        logic ep;
        logic dp;
        logic et;
        @(posedge clk);
        rs = rst;
        cyc++;
        @(negedge clk);
        if (rs) begin
            en_q.delete();
            dir_q.delete();
            exp_en   = 1'b0;
            exp_dir  = 1'b0;
            last_rst = cyc;
        end
        ep = 1'b0;
        dp = 1'b0;
        if (!rs && en_q.size() > 0 && en_q[0] == cyc) begin
            void'(en_q.pop_front());
            ep     = 1'b1;
            exp_en = ~exp_en;
        end
        if (!rs && dir_q.size() > 0 && dir_q[0] == cyc) begin
            void'(dir_q.pop_front());
            dp      = 1'b1;
            exp_dir = ~exp_dir;
        end
        et = (!rs && cyc != last_rst && ((cyc - last_rst) % TP) == 0);
        chk("en_pulse", en_pulse, ep);
        chk("dir_pulse", dir_pulse, dp);
        chk("en", en, exp_en);
        chk("dir", dir, exp_dir);
        chk("tick", tick, et);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Call right after raising a button: the raw level is sampled at the
    // next edge R = cyc+1, and the debounced press lands at R+1+DEB.
    task automatic expect_en_press();
        en_q.push_back(cyc + DEB + 2);
    endtask

    task automatic expect_dir_press();
        dir_q.push_back(cyc + DEB + 2);
    endtask

    initial begin
        // Reset held for 3 edges, then idle long enough to see several ticks.
        rst = 1'b1;
        steps(3);
        rst = 1'b0;
        steps(40);

        // Clean enable press, release, then a second press.
        btn_en = 1'b1; expect_en_press();
        steps(20);
        btn_en = 1'b0;
        steps(20);
        btn_en = 1'b1; expect_en_press();
        steps(20);
        btn_en = 1'b0;
        steps(12);

        // Bouncing direction press: 1,0,1,0 at 1-2 cycle intervals, then held high.
        btn_dir = 1'b1; steps(1);
        btn_dir = 1'b0; steps(2);
        btn_dir = 1'b1; steps(1);
        btn_dir = 1'b0; steps(2);
        btn_dir = 1'b1; expect_dir_press();
        steps(20);
        btn_dir = 1'b0;
        steps(20);

        // An isolated 3-cycle glitch is one cycle too short to register.
        btn_dir = 1'b1; steps(3);
        btn_dir = 1'b0; steps(12);

        // Reset, then press both buttons before the same edge.
        rst = 1'b1; steps(2);
        rst = 1'b0; steps(3);
        btn_en = 1'b1; btn_dir = 1'b1;
        expect_en_press(); expect_dir_press();
        steps(20);
        btn_en = 1'b0; btn_dir = 1'b0;
        steps(20);

        // Reset 2 edges before the debounce would complete. The press
        // queued here must be discarded, and a fresh debounce must follow.
        btn_en = 1'b1; expect_en_press();
        steps(3);
        rst = 1'b1; steps(2);
        rst = 1'b0; expect_en_press();
        steps(20);
        btn_en = 1'b0;
        steps(20);

        chk("en_events_done", (en_q.size() == 0), 1'b1);
        chk("dir_events_done", (dir_q.size() == 0), 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
